mul32_scoreboard: RTL and testbench

//   Receive-side checker for the pipelined 32-bit Dadda multiplier (mul32p).

---
 rtl/mul32_scoreboard_if.sv | 22 ++
 rtl/mul32_scoreboard.sv | 142 ++++++++++++++
 tb/tb_mul32_scoreboard.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mul32_scoreboard_if.sv
// Issue/result bus between the multiplier stimulus side and the scoreboard.
// The master drives operands and returned results; the scoreboard answers with iss_ready.
interface mul32_scoreboard_if;
    logic        iss_valid;
    logic [31:0] iss_a;
    logic [31:0] iss_b;
    logic        iss_mode;
    logic        iss_ready;
    logic        res_valid;
    logic [31:0] res_hi;
    logic [31:0] res_lo;

    modport master (
        output iss_valid, iss_a, iss_b, iss_mode, res_valid, res_hi, res_lo,
        input  iss_ready
    );

    modport slave (
        input  iss_valid, iss_a, iss_b, iss_mode, res_valid, res_hi, res_lo,
        output iss_ready
    );
endinterface

// File: rtl/mul32_scoreboard.sv
// In-order receive-side checker for the 32x32 multiplier: expected products are queued
// at issue and every returned result is compared against the queue head.
module mul32_scoreboard #(
    parameter int DEPTH       = 8,
    parameter int TIMEOUT     = 64,
    parameter int STOP_ON_ERR = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    mul32_scoreboard_if.slave        sb,
    output logic [31:0]              pass_count,
    output logic [31:0]              err_count,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     busy,
    output logic                     halted,
    output logic                     ovf,
    output logic                     unf,
    output logic                     timeout,
    output logic                     fe_valid,
    output logic [63:0]              fe_exp,
    output logic [63:0]              fe_got
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [AW:0]   LVL_FULL = (AW + 1)'(DEPTH);
    localparam logic [TW-1:0] TCNT_MAX = TW'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, BUSY, HALT} state_t;
    state_t state, state_nxt;

    logic [63:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   level_nxt;
    logic [TW-1:0] tcnt, tcnt_nxt;
    logic signed [63:0] exp_p0;
    logic [63:0]   got_p0, head;
    logic          push, pop, ovf_ev, unf_ev, match_ev, mis_ev, to_ev, fault_ev;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Extending both operands to 64 bits (sign or zero) lets one 64-bit multiply serve both modes.
    function automatic logic signed [63:0] exp_product(input logic [31:0] a,
                                                       input logic [31:0] b,
                                                       input logic        mode);
        logic signed [63:0] a_ext, b_ext;
        a_ext = mode ? {{32{a[31]}}, a} : {32'd0, a};
        b_ext = mode ? {{32{b[31]}}, b} : {32'd0, b};
        return a_ext * b_ext;
    endfunction

    // Issue/return stage: expected value, handshake and fault events
    always_comb begin
        exp_p0   = exp_product(sb.iss_a, sb.iss_b, sb.iss_mode);
        got_p0   = {sb.res_hi, sb.res_lo};
        head     = mem[rd_ptr];
        push     = sb.iss_valid & sb.iss_ready;
        ovf_ev   = sb.iss_valid & ~sb.iss_ready;
        pop      = sb.res_valid & (level != '0);
        unf_ev   = sb.res_valid & (level == '0);
        match_ev = pop & (got_p0 == head);
        mis_ev   = pop & (got_p0 != head);
        level_nxt = level + (AW + 1)'(push) - (AW + 1)'(pop);
        if (pop || level == '0)
            tcnt_nxt = '0;
        else if (tcnt == TCNT_MAX)
            tcnt_nxt = tcnt;
        else
            tcnt_nxt = tcnt + TW'(1);
        to_ev    = (tcnt_nxt == TCNT_MAX) && (tcnt != TCNT_MAX);
        fault_ev = ovf_ev | unf_ev | mis_ev | to_ev;
    end

    always_ff @(posedge clk) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (clr)
            state_nxt = (level_nxt != '0) ? BUSY : IDLE;
        else if (STOP_ON_ERR != 0 && fault_ev)
            state_nxt = HALT;
        else if (state != HALT)
            state_nxt = (level_nxt != '0) ? BUSY : IDLE;
    end

    always_comb begin
        busy         = (state == BUSY);
        halted       = (state == HALT);
        sb.iss_ready = (level != LVL_FULL) && (state != HALT);
    end

    // FIFO stage: pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            level <= level_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= exp_p0;
    end

    // Status stage: clr overrides any same-cycle update
    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            pass_count <= '0;
            err_count  <= '0;
            ovf        <= 1'b0;
            unf        <= 1'b0;
            timeout    <= 1'b0;
            tcnt       <= '0;
            fe_valid   <= 1'b0;
            fe_exp     <= '0;
            fe_got     <= '0;
        end else begin
            if (match_ev)        pass_count <= sat_inc(pass_count);
            if (mis_ev | unf_ev) err_count  <= sat_inc(err_count);
            if (ovf_ev) ovf     <= 1'b1;
            if (unf_ev) unf     <= 1'b1;
            if (to_ev)  timeout <= 1'b1;
            tcnt <= tcnt_nxt;
            if (mis_ev && !fe_valid) begin
                fe_valid <= 1'b1;
                fe_exp   <= head;
                fe_got   <= got_p0;
            end
        end
    end
endmodule

// File: tb/tb_mul32_scoreboard.sv
// Bench for mul32_scoreboard: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mul32_scoreboard;
    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 16;
    localparam int LW      = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic clr = 1'b0;
    always #5 clk = ~clk;

    mul32_scoreboard_if sb0();
    mul32_scoreboard_if sb1();

    logic [31:0]   pass0, err0, pass1, err1;
    logic [LW-1:0] level0, level1;
    logic          busy0, halted0, ovf0, unf0, to0, fev0;
    logic          busy1, halted1, ovf1, unf1, to1, fev1;
    logic [63:0]   fee0, feg0, fee1, feg1;

    mul32_scoreboard #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .STOP_ON_ERR(0)) dut0 (
        .clk(clk), .rst(rst), .clr(clr), .sb(sb0),
        .pass_count(pass0), .err_count(err0), .level(level0), .busy(busy0),
        .halted(halted0), .ovf(ovf0), .unf(unf0), .timeout(to0),
        .fe_valid(fev0), .fe_exp(fee0), .fe_got(feg0)
    );

    mul32_scoreboard #(.DEPTH(DEPTH), .TIMEOUT(64), .STOP_ON_ERR(1)) dut1 (
        .clk(clk), .rst(rst), .clr(clr), .sb(sb1),
        .pass_count(pass1), .err_count(err1), .level(level1), .busy(busy1),
        .halted(halted1), .ovf(ovf1), .unf(unf1), .timeout(to1),
        .fe_valid(fev1), .fe_exp(fee1), .fe_got(feg1)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Reference model state for dut0
    logic [63:0] mq[$];
    logic [31:0] m_pass = '0, m_err = '0;
    logic        m_ovf = 1'b0, m_unf = 1'b0, m_to = 1'b0, m_fev = 1'b0;
    logic [63:0] m_fee = '0, m_feg = '0, m_got, m_head;
    int          m_tcnt = 0, m_old;
    bit          m_pop;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b,
                                             input logic mode);
        longint sa, sbv;
        if (mode) begin
            sa  = longint'(int'(a));
            sbv = longint'(int'(b));
            return sa * sbv;
        end
        return {32'd0, a} * {32'd0, b};
    endfunction

    function automatic logic [31:0] inc_sat(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Model: updated from the inputs seen at each rising edge
    initial forever begin
        @(posedge clk);
        if (!rst) begin
            mq.delete();
            m_pass = '0; m_err = '0; m_ovf = 0; m_unf = 0; m_to = 0; m_fev = 0;
            m_fee = '0; m_feg = '0; m_tcnt = 0;
        end else begin
            m_old = mq.size();
            m_got = {sb0.res_hi, sb0.res_lo};
            m_pop = sb0.res_valid && (m_old > 0);
            if (sb0.res_valid && m_old == 0) begin
                m_unf = 1'b1;
                m_err = inc_sat(m_err);
            end
            if (m_pop) begin
                m_head = mq.pop_front();
                if (m_head == m_got) m_pass = inc_sat(m_pass);
                else begin
                    m_err = inc_sat(m_err);
                    if (!m_fev) begin m_fev = 1'b1; m_fee = m_head; m_feg = m_got; end
                end
            end
            if (sb0.iss_valid) begin
                if (m_old < DEPTH) mq.push_back(ref_prod(sb0.iss_a, sb0.iss_b, sb0.iss_mode));
                else m_ovf = 1'b1;
            end
            if (m_pop || m_old == 0) m_tcnt = 0;
            else if (m_tcnt < TIMEOUT) m_tcnt++;
            if (m_tcnt == TIMEOUT) m_to = 1'b1;
            if (clr) begin
                m_pass = '0; m_err = '0; m_ovf = 0; m_unf = 0; m_to = 0; m_fev = 0;
                m_fee = '0; m_feg = '0; m_tcnt = 0;
            end
        end
    end

    // Compare dut0 against the model on every falling edge
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("pass_count", pass0, m_pass);
            chk("err_count", err0, m_err);
            chk("level", level0, mq.size());
            chk("busy", busy0, mq.size() != 0);
            chk("halted", halted0, 0);
            chk("iss_ready", sb0.iss_ready, mq.size() < DEPTH);
            chk("ovf", ovf0, m_ovf);
            chk("unf", unf0, m_unf);
            chk("timeout", to0, m_to);
            chk("fe_valid", fev0, m_fev);
            chk("fe_exp", fee0, m_fee);
            chk("fe_got", feg0, m_feg);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic issue0(input logic [31:0] a, input logic [31:0] b, input logic m);
        sb0.iss_valid = 1'b1; sb0.iss_a = a; sb0.iss_b = b; sb0.iss_mode = m;
    endtask

    task automatic ret0(input logic [63:0] v);
        sb0.res_valid = 1'b1; sb0.res_hi = v[63:32]; sb0.res_lo = v[31:0];
    endtask

    task automatic idle0();
        sb0.iss_valid = 1'b0; sb0.res_valid = 1'b0;
    endtask

    task automatic issue1(input logic [31:0] a, input logic [31:0] b);
        sb1.iss_valid = 1'b1; sb1.iss_a = a; sb1.iss_b = b; sb1.iss_mode = 1'b0;
    endtask

    task automatic ret1(input logic [63:0] v);
        sb1.res_valid = 1'b1; sb1.res_hi = v[63:32]; sb1.res_lo = v[31:0];
    endtask

    task automatic idle1();
        sb1.iss_valid = 1'b0; sb1.res_valid = 1'b0;
    endtask

    task automatic pulse_clr();
        clr = 1'b1; step(); clr = 1'b0;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(7))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int res_pct;
        logic [63:0] v;
        sb0.iss_valid = 0; sb0.iss_a = '0; sb0.iss_b = '0; sb0.iss_mode = 0;
        sb0.res_valid = 0; sb0.res_hi = '0; sb0.res_lo = '0;
        sb1.iss_valid = 0; sb1.iss_a = '0; sb1.iss_b = '0; sb1.iss_mode = 0;
        sb1.res_valid = 0; sb1.res_hi = '0; sb1.res_lo = '0;

        chk("model_u_3x5", ref_prod(32'd3, 32'd5, 1'b0), 64'h0F);
        chk("model_s_m1x2", ref_prod(32'hFFFF_FFFF, 32'd2, 1'b1), 64'hFFFF_FFFF_FFFF_FFFE);
        chk("model_u_m1x2", ref_prod(32'hFFFF_FFFF, 32'd2, 1'b0), 64'h0000_0001_FFFF_FFFE);

        step(2);
        chk_en = 1'b1;
        chk("rst_pass", pass0, 0);
        chk("rst_err", err0, 0);
        chk("rst_level", level0, 0);
        chk("rst_fe_valid", fev0, 0);
        rst = 1'b1;
        step();

        // Unsigned 3*5 returned three cycles after issue
        issue0(32'd3, 32'd5, 1'b0); step(); idle0(); step(2);
        ret0(64'h0F); step(); idle0();
        chk("t1_pass", pass0, 1);
        chk("t1_err", err0, 0);
        chk("t1_level", level0, 0);
        chk("t1_busy", busy0, 0);

        // Signed then unsigned interpretation of the same operands
        pulse_clr();
        issue0(32'hFFFF_FFFF, 32'd2, 1'b1); step();
        issue0(32'hFFFF_FFFF, 32'd2, 1'b0); step();
        sb0.iss_valid = 1'b0;
        ret0(64'hFFFF_FFFF_FFFF_FFFE); step();
        ret0(64'h0000_0001_FFFF_FFFE); step(); idle0();
        chk("t2_pass", pass0, 2);
        chk("t2_err", err0, 0);

        // Mismatch capture, second mismatch must not overwrite it
        issue0(32'd3, 32'd5, 1'b0); step(); idle0();
        ret0(64'h10); step(); idle0();
        chk("t3_err", err0, 1);
        chk("t3_fe_valid", fev0, 1);
        chk("t3_fe_exp", fee0, 64'h0F);
        chk("t3_fe_got", feg0, 64'h10);
        issue0(32'd2, 32'd2, 1'b0); step(); idle0();
        ret0(64'h5); step(); idle0();
        chk("t3_err2", err0, 2);
        chk("t3_fe_exp2", fee0, 64'h0F);
        chk("t3_fe_got2", feg0, 64'h10);

        // Fill to DEPTH, overflow, pop+push at full
        pulse_clr();
        for (int i = 0; i < DEPTH; i++) begin
            issue0(pick(), pick(), 1'($urandom_range(1))); step();
        end
        idle0();
        chk("t4_level_full", level0, DEPTH);
        chk("t4_ready_full", sb0.iss_ready, 0);
        issue0(32'd7, 32'd7, 1'b0); step(); idle0();
        chk("t4_ovf", ovf0, 1);
        chk("t4_level_ovf", level0, DEPTH);
        issue0(32'd9, 32'd9, 1'b0); ret0(mq[0]);
        chk("t4_ready_poppush", sb0.iss_ready, 0);
        step(); idle0();
        chk("t4_level_after", level0, DEPTH - 1);
        chk("t4_pass_after", pass0, 1);
        for (int i = 0; i < DEPTH - 1; i++) begin
            ret0(mq[0]); step();
        end
        idle0();
        chk("t4_level_drained", level0, 0);
        chk("t4_pass_drained", pass0, DEPTH);

        // Underflow, then clr clears everything
        pulse_clr();
        ret0(64'h1234); step(); idle0();
        chk("t5_unf", unf0, 1);
        chk("t5_err", err0, 1);
        pulse_clr();
        chk("t5_clr_unf", unf0, 0);
        chk("t5_clr_err", err0, 0);
        chk("t5_clr_ovf", ovf0, 0);
        chk("t5_clr_fe_valid", fev0, 0);

        // Timeout after TIMEOUT idle cycles, then reset with entries pending
        issue0(32'd1, 32'd1, 1'b0); step(); idle0();
        step(TIMEOUT - 1);
        chk("t6_timeout_early", to0, 0);
        step();
        chk("t6_timeout", to0, 1);
        ret0(mq[0]); step(); idle0();
        for (int i = 0; i < 5; i++) begin
            issue0(pick(), pick(), 1'b1); step();
        end
        idle0();
        chk("t6_level5", level0, 5);
        rst = 1'b0; step();
        chk("t6_rst_level", level0, 0);
        chk("t6_rst_pass", pass0, 0);
        chk("t6_rst_timeout", to0, 0);
        chk("t6_rst_busy", busy0, 0);
        chk("t6_rst_fe_exp", fee0, 0);
        rst = 1'b1; step();

        // STOP_ON_ERR instance: halt on mismatch, pops continue, pushes refused
        chk("h_ready_init", sb1.iss_ready, 1);
        issue1(32'd3, 32'd5); step();
        issue1(32'd2, 32'd2); step(); idle1();
        ret1(64'h10); step(); idle1();
        chk("h_halted", halted1, 1);
        chk("h_ready", sb1.iss_ready, 0);
        chk("h_err", err1, 1);
        chk("h_level", level1, 1);
        ret1(64'h4); step(); idle1();
        chk("h_pass_in_halt", pass1, 1);
        chk("h_level_in_halt", level1, 0);
        issue1(32'd1, 32'd1); step(); idle1();
        chk("h_ovf", ovf1, 1);
        chk("h_level_refused", level1, 0);
        pulse_clr();
        chk("h_clr_halted", halted1, 0);
        chk("h_clr_ready", sb1.iss_ready, 1);
        chk("h_clr_err", err1, 0);

        // Randomized traffic against the model
        for (int blk = 0; blk < 20; blk++) begin
            case ($urandom_range(2))
                0: res_pct = 5;
                1: res_pct = 45;
                default: res_pct = 80;
            endcase
            for (int c = 0; c < 100; c++) begin
                sb0.iss_valid = ($urandom_range(99) < 50);
                sb0.iss_a = pick(); sb0.iss_b = pick(); sb0.iss_mode = 1'($urandom_range(1));
                if ($urandom_range(99) < res_pct) begin
                    if (mq.size() > 0 && $urandom_range(9) != 0) v = mq[0];
                    else v = {$urandom, $urandom};
                    ret0(v);
                end else begin
                    sb0.res_valid = 1'b0;
                end
                clr = ($urandom_range(199) == 0);
                step();
            end
        end
        idle0(); clr = 1'b0;
        step(2);
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
